// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for an NxN output-stationary systolic array (clear, skewed feed,
// drain, capture). Define SYSTOLIC_CTRL_PERF_EN to add handshake/stall perf counters.
module systolic_ctrl #(
  parameter int unsigned W     = 32,
  parameter int unsigned N     = 3,
  parameter int unsigned DRAIN = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [W*N*N-1:0]     i_A_mat,
  input  logic [W*N*N-1:0]     i_B_mat,
  output logic                 o_arr_clr,
  output logic                 o_arr_en,
  output logic [W*N-1:0]       o_arr_A,
  output logic [W*N-1:0]       o_arr_B,
  input  logic [2*W*N*N-1:0]   i_arr_C,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_busy,
  output logic [2*W*N*N-1:0]   o_C
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [15:0]          o_perf_ops,
  output logic [15:0]          o_perf_stall
`endif
);

  localparam int unsigned FeedLen = 3 * N - 2;
  localparam int unsigned CntW    = $clog2(3 * N - 1);
  localparam int unsigned DrnW    = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  typedef enum logic [2:0] {StIdle, StClear, StFeed, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DrnW-1:0]       drn_q, drn_d;
  logic [W*N*N-1:0]      a_q, b_q;
  logic [W*N-1:0]        arr_a_q, arr_a_d, arr_b_q, arr_b_d;
  logic                  arr_clr_q, arr_en_q, valid_q, busy_q;
  logic [2*W*N*N-1:0]    c_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    unique case (state_q)
      StIdle:  if (i_valid) state_d = StClear;
      StClear: begin
        state_d = StFeed;
        cnt_d   = '0;
      end
      StFeed: begin
        if (cnt_q == CntW'(FeedLen - 1)) begin
          state_d = (DRAIN == 0) ? StDone : StDrain;
          drn_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDrain: begin
        if (drn_q == DrnW'(DRAIN - 1)) state_d = StDone;
        else                           drn_d   = drn_q + DrnW'(1);
      end
      StDone:  if (i_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Edge vectors for the upcoming cycle: row i of A and column i of B share skew offset k.
  always_comb begin
    int k;
    k       = 0;
    arr_a_d = '0;
    arr_b_d = '0;
    if (state_d == StFeed) begin
      for (int i = 0; i < int'(N); i++) begin
        k = int'(cnt_d) - i;
        if (k >= 0 && k < int'(N)) begin
          arr_a_d[i*W +: W] = a_q[(i*int'(N) + k)*W +: W];
          arr_b_d[i*W +: W] = b_q[(k*int'(N) + i)*W +: W];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      drn_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      arr_a_q   <= '0;
      arr_b_q   <= '0;
      arr_clr_q <= 1'b0;
      arr_en_q  <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      c_q       <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drn_q     <= drn_d;
      if (state_q == StIdle && i_valid) begin
        a_q <= i_A_mat;
        b_q <= i_B_mat;
      end
      arr_a_q   <= arr_a_d;
      arr_b_q   <= arr_b_d;
      arr_clr_q <= (state_d == StClear);
      arr_en_q  <= (state_d == StFeed) || (state_d == StDrain);
      valid_q   <= (state_d == StDone);
      busy_q    <= (state_d != StIdle);
      if (state_d == StDone && state_q != StDone) c_q <= i_arr_C;
    end
  end

  assign o_ready   = (state_q == StIdle);
  assign o_arr_clr = arr_clr_q;
  assign o_arr_en  = arr_en_q;
  assign o_arr_A   = arr_a_q;
  assign o_arr_B   = arr_b_q;
  assign o_valid   = valid_q;
  assign o_busy    = busy_q;
  assign o_C       = c_q;

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [15:0] perf_ops_q, perf_stall_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else if (state_q == StDone) begin
      if (i_ready && perf_ops_q != 16'hFFFF)    perf_ops_q   <= perf_ops_q + 16'd1;
      if (!i_ready && perf_stall_q != 16'hFFFF) perf_stall_q <= perf_stall_q + 16'd1;
    end
  end

  assign o_perf_ops   = perf_ops_q;
  assign o_perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed testbench for systolic_ctrl with a behavioural 3x3 output-stationary array model.
module tb_systolic_ctrl;

  localparam int unsigned W = 32;
  localparam int unsigned N = 3;
  localparam int unsigned DRAIN = 2;
  localparam int unsigned MW = W * N * N;
  localparam int unsigned CW = 2 * W * N * N;

  logic          clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [MW-1:0] i_A_mat = '0;
  logic [MW-1:0] i_B_mat = '0;
  logic          arr_clr, arr_en;
  logic [W*N-1:0] arr_A, arr_B;
  logic [CW-1:0] arr_C;
  logic          o_valid;
  logic          i_ready = 1'b1;
  logic          o_busy;
  logic [CW-1:0] o_C;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [15:0]   perf_ops, perf_stall;
`endif

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  systolic_ctrl #(.W(W), .N(N), .DRAIN(DRAIN)) dut (
    .i_clk     (clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_A_mat   (i_A_mat),
    .i_B_mat   (i_B_mat),
    .o_arr_clr (arr_clr),
    .o_arr_en  (arr_en),
    .o_arr_A   (arr_A),
    .o_arr_B   (arr_B),
    .i_arr_C   (arr_C),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_busy    (o_busy),
    .o_C       (o_C)
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    .o_perf_ops   (perf_ops),
    .o_perf_stall (perf_stall)
`endif
  );

  // Behavioural array: A moves east, B moves south, each PE accumulates a*b.
  logic [2*W-1:0] acc [N][N];
  logic [W-1:0]   pa [N][N];
  logic [W-1:0]   pb [N][N];

  function automatic logic [W-1:0] a_in(input int r, input int c);
    return (c == 0) ? arr_A[r*W +: W] : pa[r][c-1];
  endfunction

  function automatic logic [W-1:0] b_in(input int r, input int c);
    return (r == 0) ? arr_B[c*W +: W] : pb[r-1][c];
  endfunction

  always @(posedge clk) begin
    for (int r = 0; r < int'(N); r++) begin
      for (int c = 0; c < int'(N); c++) begin
        if (arr_clr) begin
          acc[r][c] <= '0;
          pa[r][c]  <= '0;
          pb[r][c]  <= '0;
        end else if (arr_en) begin
          acc[r][c] <= acc[r][c] + ((2*W)'(a_in(r, c)) * (2*W)'(b_in(r, c)));
          pa[r][c]  <= a_in(r, c);
          pb[r][c]  <= b_in(r, c);
        end
      end
    end
  end

  always_comb begin
    arr_C = '0;
    for (int r = 0; r < int'(N); r++)
      for (int c = 0; c < int'(N); c++)
        arr_C[(r*int'(N) + c)*2*W +: 2*W] = acc[r][c];
  end

  // Element (r,c) = k + mr*r + mc*c, plus d on the diagonal.
  function automatic logic [MW-1:0] mk(input int k, input int mr, input int mc, input int d);
    logic [MW-1:0] m;
    m = '0;
    for (int r = 0; r < int'(N); r++)
      for (int c = 0; c < int'(N); c++)
        m[(r*int'(N) + c)*W +: W] = W'(k + mr*r + mc*c + ((r == c) ? d : 0));
    return m;
  endfunction

  function automatic logic [CW-1:0] matmul(input logic [MW-1:0] a, input logic [MW-1:0] b);
    logic [CW-1:0]  res;
    logic [2*W-1:0] s;
    res = '0;
    for (int r = 0; r < int'(N); r++) begin
      for (int c = 0; c < int'(N); c++) begin
        s = '0;
        for (int k = 0; k < int'(N); k++)
          s = s + ((2*W)'(a[(r*int'(N) + k)*W +: W]) * (2*W)'(b[(k*int'(N) + c)*W +: W]));
        res[(r*int'(N) + c)*2*W +: 2*W] = s;
      end
    end
    return res;
  endfunction

  // Drives one operand pair, returns edges from accept to o_valid (-1 on timeout).
  task automatic start_and_wait(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                output int lat);
    int g;
    g = 0;
    @(negedge clk);
    i_A_mat = a;
    i_B_mat = b;
    i_valid = 1'b1;
    while (!o_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_A_mat = ~a;
    i_B_mat = ~b;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (o_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    #3;
    n_checks++;
    if ({o_ready, o_busy, o_valid, arr_en, arr_clr} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy/busy/vld/en/clr=%b want 10000",
               {o_ready, o_busy, o_valid, arr_en, arr_clr});
    end
    @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o_C !== '0 || arr_A !== '0 || arr_B !== '0) begin
      n_fail++;
      $display("FAIL reset_data: o_C/arr_A/arr_B not zero");
    end
    n_checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got ready=%b busy=%b want 1 0", o_ready, o_busy);
    end
`ifdef SYSTOLIC_CTRL_PERF_EN
    n_checks++;
    if (perf_ops !== 16'd0 || perf_stall !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_perf: got ops=%0d stall=%0d want 0 0", perf_ops, perf_stall);
    end
`endif
  endtask

  task automatic test_identity;
    int lat;
    start_and_wait(mk(0, 0, 0, 1), mk(1, 3, 1, 0), lat);
    n_checks++;
    if (lat !== 10) begin
      n_fail++;
      $display("FAIL ident_latency: got %0d want 10", lat);
    end
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (o_C[i*2*W +: 2*W] !== 64'(i + 1)) begin
        n_fail++;
        $display("FAIL ident_C[%0d]: got %0d want %0d", i, o_C[i*2*W +: 2*W], i + 1);
      end
    end
  endtask

  task automatic test_const;
    int clr_extra;
    clr_extra = 0;
    @(negedge clk);
    i_A_mat = mk(2, 0, 0, 0);
    i_B_mat = mk(3, 0, 0, 0);
    i_valid = 1'b1;
    n_checks++;
    if (arr_clr !== 1'b0) begin
      n_fail++;
      $display("FAIL const_clr_pre: got %b want 0", arr_clr);
    end
    @(negedge clk);
    i_valid = 1'b0;
    n_checks++;
    if (arr_clr !== 1'b1 || arr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL const_clr_pulse: got clr=%b en=%b want 1 0", arr_clr, arr_en);
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (arr_clr) clr_extra++;
      if (o_valid) break;
    end
    n_checks++;
    if (clr_extra !== 0) begin
      n_fail++;
      $display("FAIL const_clr_once: got %0d extra pulses want 0", clr_extra);
    end
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (o_C[i*2*W +: 2*W] !== 64'd18) begin
        n_fail++;
        $display("FAIL const_C[%0d]: got %0d want 18", i, o_C[i*2*W +: 2*W]);
      end
    end
  endtask

  task automatic test_skew;
    logic [MW-1:0] a, b;
    logic [CW-1:0] exp_c;
    int lat;
    a = mk(0, 10, 1, 0);
    b = mk(100, 10, 1, 0);
    exp_c = matmul(a, b);
    @(negedge clk);
    i_A_mat = a;
    i_B_mat = b;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    i_A_mat = '1;
    i_B_mat = '1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (arr_A !== {32'd20, 32'd11, 32'd2} || arr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL skew_A_t2: got %h en=%b want rows 2,11,20", arr_A, arr_en);
    end
    n_checks++;
    if (arr_B !== {32'd102, 32'd111, 32'd120}) begin
      n_fail++;
      $display("FAIL skew_B_t2: got %h want cols 120,111,102", arr_B);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (arr_A !== {32'd22, 32'd0, 32'd0} || arr_B !== {32'd122, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL skew_t4: got A=%h B=%h want A row2=22 B col2=122", arr_A, arr_B);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (arr_A !== '0 || arr_B !== '0 || arr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL skew_t6: got A=%h B=%h en=%b want 0 0 1", arr_A, arr_B, arr_en);
    end
    @(negedge clk);
    n_checks++;
    if (arr_A !== '0 || arr_B !== '0 || arr_en !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL skew_drain: got A=%h B=%h en=%b vld=%b", arr_A, arr_B, arr_en, o_valid);
    end
    lat = -1;
    for (int k = 9; k <= 40; k++) begin
      @(negedge clk);
      if (o_valid) begin
        lat = k;
        break;
      end
    end
    n_checks++;
    if (lat !== 10 || o_C !== exp_c) begin
      n_fail++;
      $display("FAIL skew_result: latency=%0d want 10, C=%h want %h", lat, o_C, exp_c);
    end
  endtask

  task automatic test_stall;
    int lat;
    @(negedge clk);
    i_rst_n = 1'b0;
    @(negedge clk);
    i_rst_n = 1'b1;
    i_ready = 1'b0;
    start_and_wait(mk(0, 0, 0, 1), mk(1, 3, 1, 0), lat);
    n_checks++;
    if (lat !== 10) begin
      n_fail++;
      $display("FAIL stall_latency: got %0d want 10", lat);
    end
    i_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got vld=%b rdy=%b busy=%b want 1 0 1",
                 k, o_valid, o_ready, o_busy);
      end
      n_checks++;
      if (o_C !== matmul(mk(0, 0, 0, 1), mk(1, 3, 1, 0))) begin
        n_fail++;
        $display("FAIL stall_C[%0d]: got %h", k, o_C);
      end
    end
    i_ready = 1'b1;
    i_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: got vld=%b rdy=%b want 0 1", o_valid, o_ready);
    end
`ifdef SYSTOLIC_CTRL_PERF_EN
    n_checks++;
    if (perf_stall !== 16'd5 || perf_ops !== 16'd1) begin
      n_fail++;
      $display("FAIL stall_perf: got stall=%0d ops=%0d want 5 1", perf_stall, perf_ops);
    end
`endif
  endtask

  task automatic test_reset_mid;
    int lat;
    @(negedge clk);
    i_A_mat = mk(2, 0, 0, 0);
    i_B_mat = mk(3, 0, 0, 0);
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (arr_en !== 1'b1 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: got en=%b busy=%b want 1 1", arr_en, o_busy);
    end
    i_rst_n = 1'b0;
    #1;
    n_checks++;
    if (arr_en !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async: got en=%b busy=%b rdy=%b vld=%b want 0 0 1 0",
               arr_en, o_busy, o_ready, o_valid);
    end
    @(negedge clk);
    i_rst_n = 1'b1;
    start_and_wait(mk(0, 0, 0, 1), mk(0, 0, 0, 1), lat);
    n_checks++;
    if (lat !== 10) begin
      n_fail++;
      $display("FAIL midrst_latency: got %0d want 10", lat);
    end
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (o_C[i*2*W +: 2*W] !== ((i % 4 == 0) ? 64'd1 : 64'd0)) begin
        n_fail++;
        $display("FAIL midrst_C[%0d]: got %0d", i, o_C[i*2*W +: 2*W]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [MW-1:0] a1, b1, a2, b2;
    int lat;
    a1 = mk(0, 0, 0, 2);
    b1 = mk(1, 3, 1, 0);
    a2 = mk(1, 0, 0, 0);
    b2 = mk(0, 0, 0, 1);
    i_ready = 1'b1;
    @(negedge clk);
    i_A_mat = a1;
    i_B_mat = b1;
    i_valid = 1'b1;
    @(negedge clk);
    i_A_mat = a2;
    i_B_mat = b2;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (o_valid) begin
        lat = k;
        break;
      end
    end
    n_checks++;
    if (lat !== 10 || o_C !== matmul(a1, b1)) begin
      n_fail++;
      $display("FAIL b2b_first: latency=%0d want 10, C=%h", lat, o_C);
    end
    @(negedge clk);
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_gap: got vld=%b rdy=%b want 0 1", o_valid, o_ready);
    end
    @(negedge clk);
    i_valid = 1'b0;
    n_checks++;
    if (o_ready !== 1'b0 || o_busy !== 1'b1 || arr_clr !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: got rdy=%b busy=%b clr=%b want 0 1 1", o_ready, o_busy, arr_clr);
    end
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (o_valid) begin
        lat = k;
        break;
      end
    end
    n_checks++;
    if (lat !== 10 || o_C !== matmul(a2, b2)) begin
      n_fail++;
      $display("FAIL b2b_second: latency=%0d want 10, C=%h", lat, o_C);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_const();
    test_skew();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
